// File: rtl/tape_loader.sv
// Tape initialiser: streams symbols into tape cells from 0 up, blank-fills the rest,
// then releases the core. Optional load_checksum output under TAPE_LOADER_CHECKSUM_EN.
module tape_loader #(
    parameter int               ADDR_W      = 9,
    parameter int               SYM_W       = 3,
    parameter int               TAPE_DEPTH  = 512,
    parameter logic [SYM_W-1:0] BLANK_SYM   = '0,
    parameter int               HOLD_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SYM_W-1:0]  in_sym,
    input  logic              in_last,
    output logic              tape_we,
    output logic [ADDR_W-1:0] tape_addr,
    output logic [SYM_W-1:0]  tape_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              load_overflow
`ifdef TAPE_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]        load_checksum
`endif
);

    // state | meaning
    // LOAD  | accepting stream symbols, one tape write per accept
    // FILL  | writing BLANK_SYM to the cells the stream did not cover
    // HOLD  | tape complete, core still held in reset for HOLD_CYCLES
    // RUN   | core released; loader idle until reset
    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    localparam int              LAST_I      = TAPE_DEPTH - 1;
    localparam logic [ADDR_W:0] LAST_CELL   = LAST_I[ADDR_W:0];
    localparam logic [ADDR_W:0] DEPTH_CNT   = TAPE_DEPTH[ADDR_W:0];
    localparam int              HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int              HOLD_LOAD_I = HOLD_CYCLES - 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_LOAD_I[HOLD_W-1:0];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic              in_ready_q, in_ready_d;
    logic              tape_we_q, tape_we_d;
    logic [ADDR_W-1:0] tape_addr_q, tape_addr_d;
    logic [SYM_W-1:0]  tape_wdata_q, tape_wdata_d;
    logic              core_reset_q, core_reset_d;
    logic              load_done_q, load_done_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              load_overflow_q, load_overflow_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic accept;
    logic at_last_cell;

    assign accept       = in_valid && in_ready_q && (state_q == S_LOAD);
    assign at_last_cell = (ptr_q == LAST_CELL);

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        in_ready_d      = in_ready_q;
        tape_we_d       = 1'b0;
        tape_addr_d     = tape_addr_q;
        tape_wdata_d    = tape_wdata_q;
        core_reset_d    = core_reset_q;
        load_done_d     = load_done_q;
        load_count_d    = load_count_q;
        load_overflow_d = load_overflow_q;
        hold_cnt_d      = hold_cnt_q;

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    tape_we_d    = 1'b1;
                    tape_addr_d  = ptr_q[ADDR_W-1:0];
                    tape_wdata_d = in_sym;
                    ptr_d        = ptr_q + 1'b1;
                    if (load_count_q != DEPTH_CNT) begin
                        load_count_d = load_count_q + 1'b1;
                    end
                    // The last cell ends the load whether or not the stream says so;
                    // a missing in_last there means the stream was too long.
                    if (at_last_cell) begin
                        in_ready_d = 1'b0;
                        state_d    = S_HOLD;
                        hold_cnt_d = HOLD_LOAD;
                        if (!in_last) begin
                            load_overflow_d = 1'b1;
                        end
                    end else if (in_last) begin
                        in_ready_d = 1'b0;
                        state_d    = S_FILL;
                    end
                end
            end
            S_FILL: begin
                tape_we_d    = 1'b1;
                tape_addr_d  = ptr_q[ADDR_W-1:0];
                tape_wdata_d = BLANK_SYM;
                ptr_d        = ptr_q + 1'b1;
                if (at_last_cell) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d      = S_RUN;
                    core_reset_d = 1'b0;
                    load_done_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            S_RUN: begin
                in_ready_d = 1'b0;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_LOAD;
            ptr_q           <= '0;
            in_ready_q      <= 1'b1;
            tape_we_q       <= 1'b0;
            tape_addr_q     <= '0;
            tape_wdata_q    <= '0;
            core_reset_q    <= 1'b1;
            load_done_q     <= 1'b0;
            load_count_q    <= '0;
            load_overflow_q <= 1'b0;
            hold_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            in_ready_q      <= in_ready_d;
            tape_we_q       <= tape_we_d;
            tape_addr_q     <= tape_addr_d;
            tape_wdata_q    <= tape_wdata_d;
            core_reset_q    <= core_reset_d;
            load_done_q     <= load_done_d;
            load_count_q    <= load_count_d;
            load_overflow_q <= load_overflow_d;
            hold_cnt_q      <= hold_cnt_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign tape_we       = tape_we_q;
    assign tape_addr     = tape_addr_q;
    assign tape_wdata    = tape_wdata_q;
    assign core_reset    = core_reset_q;
    assign load_done     = load_done_q;
    assign load_count    = load_count_q;
    assign load_overflow = load_overflow_q;

`ifdef TAPE_LOADER_CHECKSUM_EN
    // Only stream accepts contribute, so the sum freezes once LOAD is left.
    logic [7:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (accept) begin
            checksum_d = checksum_q + 8'(in_sym);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign load_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_tape_loader.sv
// Self-checking bench for tape_loader: vector table of streams, hand-written
// gap and mid-fill reset sequences, tape image compared against a cell-level model.
module tb_tape_loader;
    localparam int               ADDR_W      = 9;
    localparam int               SYM_W       = 3;
    localparam int               TAPE_DEPTH  = 512;
    localparam logic [SYM_W-1:0] BLANK_SYM   = '0;
    localparam int               HOLD_CYCLES = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [SYM_W-1:0]  in_sym = '0;
    logic              in_last = 1'b0;
    logic              tape_we;
    logic [ADDR_W-1:0] tape_addr;
    logic [SYM_W-1:0]  tape_wdata;
    logic              core_reset;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic              load_overflow;
`ifdef TAPE_LOADER_CHECKSUM_EN
    logic [7:0]        load_checksum;
`endif

    tape_loader #(
        .ADDR_W(ADDR_W), .SYM_W(SYM_W), .TAPE_DEPTH(TAPE_DEPTH),
        .BLANK_SYM(BLANK_SYM), .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_last(in_last),
        .tape_we(tape_we), .tape_addr(tape_addr), .tape_wdata(tape_wdata),
        .core_reset(core_reset), .load_done(load_done),
        .load_count(load_count), .load_overflow(load_overflow)
`ifdef TAPE_LOADER_CHECKSUM_EN
        ,
        .load_checksum(load_checksum)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Observed tape image and write-stream statistics, cleared while reset is high.
    int               captured [TAPE_DEPTH];
    int               wr_cnt = 0, exp_addr = 0, seq_err = 0, lat_err = 0, run_viol = 0;
    int               last_wr_cyc = -1, fall_cyc = -1;
    bit               fell = 1'b0, prev_ready = 1'b0, prev_acc = 1'b0;
    logic [SYM_W-1:0] prev_sym = '0;

    always @(negedge clock) begin
        if (reset) begin
            for (int c = 0; c < TAPE_DEPTH; c++) captured[c] <= -1;
            wr_cnt <= 0; exp_addr <= 0; seq_err <= 0; lat_err <= 0; run_viol <= 0;
            last_wr_cyc <= -1; fall_cyc <= -1; fell <= 1'b0;
            prev_ready <= 1'b0; prev_acc <= 1'b0;
        end else begin
            if ((prev_ready && (tape_we !== prev_acc)) ||
                (prev_acc && tape_we && (tape_wdata !== prev_sym)))
                lat_err <= lat_err + 1;
            if (tape_we) begin
                if (int'(tape_addr) != exp_addr) seq_err <= seq_err + 1;
                captured[tape_addr] <= int'(tape_wdata);
                wr_cnt      <= wr_cnt + 1;
                exp_addr    <= exp_addr + 1;
                last_wr_cyc <= cyc;
            end
            if (!core_reset && !fell) begin
                fell     <= 1'b1;
                fall_cyc <= cyc;
            end
            if (load_done && (tape_we || in_ready || core_reset)) run_viol <= run_viol + 1;
            prev_ready <= in_ready;
            prev_acc   <= in_valid && in_ready;
            prev_sym   <= in_sym;
        end
    end

    logic [SYM_W-1:0] syms [TAPE_DEPTH + 100];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic drive_stream(input int n, input int last_idx, input int gap_pct,
                                output int accepted);
        int i = 0, blocked = 0, guard = 0;
        while (i < n && blocked < 6 && guard < 5000) begin
            guard++;
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_sym   = syms[i];
                in_last  = (i == last_idx);
            end
            @(negedge clock);
            if (in_valid && in_ready) i++;
            else if (!in_ready) blocked++;
            @(posedge clock); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        accepted = i;
    endtask

    task automatic check_result(input string nm, input int accepted, input int exp_count,
                                input bit exp_ovf, input int run_cycles);
        int guard = 0, bad = 0, exp_cell;
`ifdef TAPE_LOADER_CHECKSUM_EN
        int sum = 0;
`endif
        chk({nm, "/accepts"}, accepted, exp_count);
        while (!load_done && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        chk({nm, "/load_done"}, load_done, 1);
        repeat (2) @(posedge clock);
        #1;
        chk({nm, "/load_count"}, load_count, exp_count);
        chk({nm, "/load_overflow"}, load_overflow, exp_ovf);
        chk({nm, "/core_reset"}, core_reset, 0);
        for (int c = 0; c < TAPE_DEPTH; c++) begin
            exp_cell = (c < exp_count) ? int'(syms[c]) : int'(BLANK_SYM);
            if (captured[c] != exp_cell) bad++;
        end
        chk({nm, "/bad_cells"}, bad, 0);
        chk({nm, "/write_count"}, wr_cnt, TAPE_DEPTH);
        chk({nm, "/addr_order_errs"}, seq_err, 0);
        chk({nm, "/write_latency_errs"}, lat_err, 0);
        chk({nm, "/hold_cycles"}, fall_cyc - last_wr_cyc, HOLD_CYCLES);
`ifdef TAPE_LOADER_CHECKSUM_EN
        for (int c = 0; c < exp_count; c++) sum += int'(syms[c]);
        chk({nm, "/checksum"}, load_checksum, sum % 256);
`endif
        for (int k = 0; k < run_cycles; k++) begin
            in_valid = 1'b1;
            in_sym   = SYM_W'($urandom_range(0, 7));
            in_last  = ($urandom_range(0, 1) == 1);
            @(posedge clock); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clock);
        @(posedge clock); #1;
        chk({nm, "/run_violations"}, run_viol, 0);
        chk({nm, "/writes_after_run"}, wr_cnt, TAPE_DEPTH);
        chk({nm, "/count_after_run"}, load_count, exp_count);
`ifdef TAPE_LOADER_CHECKSUM_EN
        chk({nm, "/checksum_frozen"}, load_checksum, sum % 256);
`endif
    endtask

    typedef struct {
        int n;
        int last_idx;
        int gap_pct;
        bit rnd;
        int base;
        int exp_count;
        bit exp_ovf;
        int run_cycles;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int acc;
        int guard;
        bit found;

        vecs[0] = '{3,   2,   0,  1'b0, 1, 3,   1'b0, 100};
        vecs[1] = '{512, 511, 0,  1'b1, 0, 512, 1'b0, 10};
        vecs[2] = '{513, -1,  0,  1'b1, 0, 512, 1'b1, 10};
        vecs[3] = '{40,  39,  30, 1'b1, 0, 40,  1'b0, 10};
        vecs[4] = '{1,   0,   0,  1'b0, 6, 1,   1'b0, 10};
        vecs[5] = '{511, 510, 10, 1'b1, 0, 511, 1'b0, 10};
        vecs[6] = '{600, -1,  20, 1'b1, 0, 512, 1'b1, 10};

        apply_reset();
        chk("rst/in_ready", in_ready, 1);
        chk("rst/core_reset", core_reset, 1);
        chk("rst/tape_we", tape_we, 0);
        chk("rst/tape_addr", tape_addr, 0);
        chk("rst/tape_wdata", tape_wdata, 0);
        chk("rst/load_done", load_done, 0);
        chk("rst/load_count", load_count, 0);
        chk("rst/load_overflow", load_overflow, 0);
`ifdef TAPE_LOADER_CHECKSUM_EN
        chk("rst/checksum", load_checksum, 0);
`endif

        for (int v = 0; v < 7; v++) begin
            apply_reset();
            for (int i = 0; i < vecs[v].n; i++)
                syms[i] = vecs[v].rnd ? SYM_W'($urandom_range(0, 7))
                                      : SYM_W'((vecs[v].base + i) % 8);
            drive_stream(vecs[v].n, vecs[v].last_idx, vecs[v].gap_pct, acc);
            check_result($sformatf("vec%0d", v), acc, vecs[v].exp_count,
                         vecs[v].exp_ovf, vecs[v].run_cycles);
        end

        // Gapped stream: valid pattern 1,0,0,1(last) carrying 5 then 7.
        apply_reset();
        acc = 0;
        syms[0] = 3'd5; syms[1] = 3'd7;
        in_valid = 1'b1; in_sym = 3'd5; in_last = 1'b0;
        @(negedge clock);
        if (in_valid && in_ready) acc++;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        chk("gaps/we0", tape_we, 1);
        chk("gaps/addr0", tape_addr, 0);
        chk("gaps/data0", tape_wdata, 5);
        @(posedge clock); #1;
        @(negedge clock);
        chk("gaps/we_gap1", tape_we, 0);
        @(posedge clock); #1;
        in_valid = 1'b1; in_sym = 3'd7; in_last = 1'b1;
        @(negedge clock);
        chk("gaps/we_gap2", tape_we, 0);
        if (in_valid && in_ready) acc++;
        @(posedge clock); #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clock);
        chk("gaps/we1", tape_we, 1);
        chk("gaps/addr1", tape_addr, 1);
        chk("gaps/data1", tape_wdata, 7);
        chk("gaps/ready_drop", in_ready, 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("gaps/fill_we", tape_we, 1);
        chk("gaps/fill_addr", tape_addr, 2);
        chk("gaps/fill_data", tape_wdata, BLANK_SYM);
        @(posedge clock); #1;
        check_result("gaps", acc, 2, 1'b0, 5);

        // One-cycle reset in the middle of FILL, then a fresh four-symbol load.
        apply_reset();
        for (int i = 0; i < 3; i++) syms[i] = SYM_W'($urandom_range(0, 7));
        drive_stream(3, 2, 0, acc);
        found = 1'b0; guard = 0;
        while (!found && guard < 1000) begin
            @(negedge clock);
            if (tape_we && tape_addr == 9'd199) found = 1'b1;
            guard++;
        end
        chk("midfill/reached_addr199", found, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midfill/core_reset", core_reset, 1);
        chk("midfill/in_ready", in_ready, 1);
        chk("midfill/load_count", load_count, 0);
        chk("midfill/tape_we", tape_we, 0);
        chk("midfill/tape_addr", tape_addr, 0);
        chk("midfill/load_done", load_done, 0);
        for (int i = 0; i < 4; i++) syms[i] = SYM_W'($urandom_range(0, 7));
        drive_stream(4, 3, 0, acc);
        check_result("restart", acc, 4, 1'b0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/tape_loader.md
Name: tape_loader

Overview:
- Initialises the 512-cell, 3-bit-symbol tape of the UTM system before execution begins.
- Sits upstream of the tape storage and of utm_core. Accepts a symbol stream over a valid/ready handshake and writes each symbol into consecutive tape cells starting at cell 0.
- Blank-fills the remaining cells, then releases the core from reset.
- While loading, owns the tape write port and holds the core in reset.

Parameters:
ADDR_W, 9, tape address width
SYM_W, 3, symbol width
TAPE_DEPTH, 512, number of tape cells (must equal 2**ADDR_W)
BLANK_SYM, 0, symbol written to cells not supplied by the stream
HOLD_CYCLES, 4, cycles core_reset stays high after fill completes (>=1)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  stream symbol valid
in_ready  output  1  loader can accept a symbol
in_sym  input  SYM_W  stream symbol
in_last  input  1  marks final symbol of the stream
tape_we  output  1  tape write enable
tape_addr  output  ADDR_W  tape write address
tape_wdata  output  SYM_W  tape write data
core_reset  output  1  reset to utm_core and tape head logic
load_done  output  1  tape initialised, core running
load_count  output  ADDR_W+1  number of stream symbols accepted
load_overflow  output  1  stream exceeded TAPE_DEPTH; excess symbols dropped

Behaviour:
- One clock: clock. Reset is synchronous and active-high on reset.
- All outputs are registered.
- Reset values:
  - state=LOAD, in_ready=1, core_reset=1
  - tape_we=0, tape_addr=0, tape_wdata=0
  - load_done=0, load_count=0, load_overflow=0
- States: LOAD -> FILL -> HOLD -> RUN. There is no exit from RUN except reset.
- LOAD:
  - Accept occurs on in_valid&&in_ready.
  - Next cycle: tape_we=1, tape_addr=ptr, tape_wdata=in_sym (write latency 1 cycle); ptr and load_count increment.
  - No accept: tape_we=0 next cycle.
  - Accept with in_last=1 at ptr<TAPE_DEPTH-1: in_ready drops the following cycle; go to FILL with ptr=next cell.
  - Accept at ptr==TAPE_DEPTH-1, with or without in_last: that write completes, in_ready drops, go to HOLD (nothing to fill).
  - If in_last was 0 on that final accept, go to HOLD and set load_overflow=1. load_overflow is sticky until reset.
  - Empty stream: a single accept with in_last=1 still writes cell 0. A zero-length load is not supported.
- FILL:
  - One write per cycle: tape_we=1, tape_wdata=BLANK_SYM, tape_addr=ptr, ptr increments.
  - After writing TAPE_DEPTH-1, go to HOLD.
  - in_ready=0 throughout.
- HOLD:
  - tape_we=0, core_reset=1.
  - Counter runs HOLD_CYCLES cycles, then go to RUN.
- RUN:
  - core_reset=0 and load_done=1, both registered on entry.
  - in_ready=0, tape_we=0.
  - in_valid is ignored.
- Address arithmetic: ptr is ADDR_W+1 bits. tape_addr is ptr[ADDR_W-1:0]; no wrap-around writes occur.
- load_count saturates at TAPE_DEPTH.
- Reset mid-operation, in any state: returns to LOAD immediately and restarts at cell 0. Partially written contents are overwritten by the new load.
- core_reset is asserted in the same cycle reset is sampled high (registered 1 on the reset edge).
- in_valid held high with in_ready=0 has no effect. in_sym/in_last need only be valid when in_valid=1.

Optional Feature:
- Macro: TAPE_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output load_checksum[7:0], reset 0.
  - Each accepted symbol adds zero-extended in_sym, modulo 256, on the accept cycle.
  - Fill symbols are excluded.
  - Value is frozen from HOLD onward.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Stream 1,2,3 (last on 3) with in_valid held high:
  - writes at addr 0,1,2, data 1,2,3, on cycles 1-3 after accept.
  - FILL writes BLANK_SYM to addr 3..511 (509 cycles), then 4 HOLD cycles.
  - core_reset falls with load_done=1; load_count=3.
  - With checksum enabled: load_checksum=6.
- Backpressure-free gaps: in_valid toggled 1,0,0,1(last) with symbols 5,7 -> addr0=5, addr1=7, tape_we low in gap cycles, load_count=2.
- Full tape: 512 symbols, in_last on the 512th -> no FILL cycles, HOLD entered directly, load_overflow=0, load_count=512.
- Overflow: 513 symbols, no in_last by 512th -> in_ready drops after 512th accept, 513th not written, load_overflow=1, core released normally.
- Reset asserted for 1 cycle mid-FILL (ptr=200) -> core_reset stays 1, state LOAD, in_ready=1, load_count=0. A new stream of 4 re-runs the full fill from addr 4.
- RUN stability: after load_done, drive in_valid=1 for 100 cycles -> tape_we never asserts, in_ready stays 0, core_reset stays 0.
